// File: rtl/bist_sequencer.sv
// Exhaustive-pattern BIST sequencer: drives every PAT_W-bit stimulus in ascending
// order, compacts the responses in a MISR and compares the signature to golden.
module bist_sequencer #(
  parameter int PAT_W = 3,
  parameter int RSP_W = 3,
  parameter int SETTLE_CYC = 1,
  parameter logic [RSP_W-1:0] MISR_SEED = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [RSP_W-1:0] golden,
  input  logic [RSP_W-1:0] rsp_in,
  output logic [PAT_W-1:0] pat_out,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [RSP_W-1:0] signature
);

  typedef enum logic [2:0] {IDLE, LOAD, SETTLE, CAPTURE, DONE} state_t;

  // Feedback taps (polynomial without the x^W term) for primitive polynomials per width.
  function automatic logic [31:0] misr_taps(input int w);
    case (w)
      2:       return 32'h0000_0003;
      3:       return 32'h0000_0003;
      4:       return 32'h0000_0003;
      5:       return 32'h0000_0005;
      6:       return 32'h0000_0003;
      7:       return 32'h0000_0003;
      8:       return 32'h0000_001D;
      9:       return 32'h0000_0011;
      10:      return 32'h0000_0009;
      11:      return 32'h0000_0005;
      12:      return 32'h0000_0053;
      13:      return 32'h0000_001B;
      14:      return 32'h0000_0443;
      15:      return 32'h0000_0003;
      16:      return 32'h0000_100B;
      default: return 32'h0000_0001;
    endcase
  endfunction

  localparam logic [31:0]      TAPS_ALL   = misr_taps(RSP_W);
  localparam logic [RSP_W-1:0] TAPS       = TAPS_ALL[RSP_W-1:0];
  localparam logic [3:0]       CNT_RELOAD = 4'(SETTLE_CYC - 1);

  function automatic logic [RSP_W-1:0] misr_next(input logic [RSP_W-1:0] m,
                                                 input logic [RSP_W-1:0] r);
    logic [RSP_W-1:0] fb;
    fb = m[RSP_W-1] ? TAPS : '0;
    return (m << 1) ^ fb ^ r;
  endfunction

  state_t     state, state_next;
  logic [3:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = LOAD;
      LOAD:    state_next = SETTLE;
      SETTLE:  if (cnt == 4'd0) state_next = CAPTURE;
      CAPTURE: state_next = (pat_out == '1) ? DONE : SETTLE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Datapath: pattern, settle counter, signature and verdict.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pat_out   <= '0;
      signature <= MISR_SEED;
      pass      <= 1'b0;
      cnt       <= 4'd0;
    end else begin
      case (state)
        LOAD: begin
          pat_out   <= '0;
          signature <= MISR_SEED;
          pass      <= 1'b0;
          cnt       <= CNT_RELOAD;
        end
        SETTLE: if (cnt != 4'd0) cnt <= cnt - 4'd1;
        CAPTURE: begin
          signature <= misr_next(signature, rsp_in);
          if (pat_out != '1) begin
            pat_out <= pat_out + PAT_W'(1);
            cnt     <= CNT_RELOAD;
          end
        end
        DONE: pass <= (signature == golden);
        default: ;
      endcase
    end
  end

  assign busy = (state != IDLE);
  assign done = (state == DONE);

endmodule

// File: doc/bist_sequencer.md
BIST_SEQUENCER -- requirements
Module: bist_sequencer

Interface
REQ-001 Parameter PAT_W, default 3: width of the stimulus pattern driven to the netlist under test.
REQ-002 Parameter RSP_W, default 3: width of the response word captured from the netlist outputs.
REQ-003 Parameter SETTLE_CYC, default 1 (legal 1..15): cycles a pattern is held before its response is captured.
REQ-004 Parameter MISR_SEED, default 0: RSP_W-bit initial signature value.
REQ-005 Clock, reset and polarity: one clock (clk); reset (rst) is asynchronous and active-high.
REQ-006 clk  in  1  sole clock; all state changes on its rising edge.
REQ-007 rst  in  1  asynchronous, active-high reset.
REQ-008 start  in  1  request to run one full test; sampled only in IDLE.
REQ-009 golden  in  RSP_W  expected signature; sampled in DONE.
REQ-010 rsp_in  in  RSP_W  combinational response of the netlist under test; bit i carries output i.
REQ-011 pat_out  out  PAT_W  registered stimulus; bit i drives netlist input i.
REQ-012 busy  out  1  high in every state except IDLE.
REQ-013 done  out  1  one-cycle pulse at the end of a run.
REQ-014 pass  out  1  result of the last run (signature == golden); held until the next run starts.
REQ-015 signature  out  RSP_W  current MISR contents.

Function
REQ-016 The FSM SHALL have states IDLE, LOAD, SETTLE, CAPTURE and DONE.
REQ-017 IDLE: start=1 -> LOAD; otherwise stay in IDLE.
REQ-018 LOAD (1 cycle): pat_out<=0, signature<=MISR_SEED, pass<=0, settle counter<=SETTLE_CYC-1; -> SETTLE.
REQ-019 SETTLE: counter decrements; at counter==0 -> CAPTURE; pat_out is held constant.
REQ-020 CAPTURE (1 cycle): the MISR absorbs rsp_in. If pat_out == all-ones -> DONE; otherwise pat_out increments, the counter reloads and the FSM -> SETTLE.
REQ-021 MISR update for RSP_W=3 (polynomial x^3+x+1), with m = signature and r = rsp_in: m0'=m2^r0; m1'=m0^m2^r1; m2'=m1^r2. For other RSP_W values the MISR SHALL use the feedback polynomial given by a per-width constant table.
REQ-022 DONE (1 cycle): done=1 and pass<=(signature==golden); -> IDLE.
REQ-023 The run is exhaustive: exactly 2^PAT_W captures per run, in ascending binary order, with no wrap of pat_out within a run.
REQ-024 Latency from the start-sampling edge to done is 1 + 2^PAT_W*(SETTLE_CYC+1) + 1 cycles; with the defaults this is 18 cycles.
REQ-025 start while busy SHALL be ignored, with no restart and no queueing.
REQ-026 start held continuously SHALL begin a new run on the cycle after DONE, via IDLE.
REQ-027 signature and pat_out SHALL keep their final values in IDLE until the next LOAD.
REQ-028 rsp_in SHALL be sampled only in CAPTURE; changes on rsp_in in any other state have no effect.

Reset
REQ-029 On rst=1, independent of clk, the block SHALL set: state=IDLE, pat_out=0, signature=MISR_SEED, busy=0, done=0, pass=0.
REQ-030 Reset asserted mid-run SHALL abort the run immediately, with no done pulse and pass=0.
REQ-031 After rst deasserts, the block SHALL need a new start to begin a run.

Verification
REQ-032 Loopback (rsp_in=pat_out), defaults, golden=3'b100: start pulse -> pat_out steps 0..7, done pulses on the 18th cycle after start, signature=3'b100, pass=1.
REQ-033 Same loopback with golden=3'b011 -> done on the same cycle, signature=3'b100, pass=0.
REQ-034 rsp_in tied 3'b000, seed 0 -> signature=3'b000 after the run; pass=1 when golden=0.
REQ-035 Pulse start again at cycle 5 of a run -> no restart; done still pulses exactly once, at cycle 18.
REQ-036 Assert rst at cycle 9 of a run -> busy=0, pat_out=0, signature=0 and pass=0 in the same cycle; no done pulse.
REQ-037 SETTLE_CYC=3 loopback -> each pattern is held 4 cycles, done arrives at cycle 34, signature=3'b100.
